serial_out_merge: RTL and testbench

Merges several single-bit serial sources (tape out, MIDI out, UART out, and further ones) onto one physical serial output pin, such as the board UART_TX line. It generalises the fixed three-source "last edge wins" merge used in the top-level wrappers:
- the channel count is a parameter;
- each channel can be masked;
- collisions are reported;
- an optional ownership lock keeps one source on the pin until it has been idle for a set time.

The block sits in the top-level wrapper, between the core's serial outputs and the pad.

---
 rtl/serial_out_merge_if.sv | 33 +++
 rtl/serial_out_merge.sv | 179 +++++++++++++++++
 tb/tb_serial_out_merge.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/serial_out_merge_if.sv
// Serial merge bus: per-channel source levels and enables in, merged pin and
// ownership/collision status out.
interface serial_out_merge_if #(
  parameter int CHANNELS = 3,
  parameter int CH_W     = ($clog2(CHANNELS) > 0 ? $clog2(CHANNELS) : 1)
) ();
  logic [CHANNELS-1:0] src_in;
  logic [CHANNELS-1:0] src_en;
  logic                tx_out;
  logic [CH_W-1:0]     active_ch;
  logic                active_valid;
  logic                collision;

  // Source side: drives the serial levels and enables, observes the merge.
  modport master (
    output src_in,
    output src_en,
    input  tx_out,
    input  active_ch,
    input  active_valid,
    input  collision
  );

  // Merge block side.
  modport slave (
    input  src_in,
    input  src_en,
    output tx_out,
    output active_ch,
    output active_valid,
    output collision
  );
endinterface

// File: rtl/serial_out_merge.sv
// serial_out_merge: merges several single-bit serial sources onto one pin.
// The highest-index channel with an enabled edge wins; simultaneous edges
// pulse collision. Optional macro SERIAL_MERGE_LOCK_EN adds an ownership lock:
// the winning channel keeps the pin until it has been idle for LOCK_CYCLES
// cycles (or is disabled), after which the pin returns to mark level.
module serial_out_merge #(
  parameter int CHANNELS    = 3,
  parameter int LOCK_CYCLES = 65536,
  parameter int CH_W        = ($clog2(CHANNELS) > 0 ? $clog2(CHANNELS) : 1)
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  serial_out_merge_if.slave bus
);

  // Elaboration-time parameter range checks.
  if (CHANNELS < 1 || CHANNELS > 16) begin : g_bad_channels
    $error("serial_out_merge: CHANNELS out of range");
  end
  if (LOCK_CYCLES < 2 || LOCK_CYCLES > (1 << 24)) begin : g_bad_lock
    $error("serial_out_merge: LOCK_CYCLES out of range");
  end

  logic [CHANNELS-1:0] r_src_old;
  logic                r_tx_out;
  logic [CH_W-1:0]     r_active_ch;
  logic                r_active_valid;
  logic                r_collision;

  logic [CHANNELS-1:0] w_edge;
  logic [CH_W-1:0]     w_win;
  logic [4:0]          w_edge_cnt;
  logic                w_any;

  logic                w_tx_nxt;
  logic [CH_W-1:0]     w_ch_nxt;
  logic                w_valid_nxt;
  logic                w_col_nxt;

  assign w_edge = (bus.src_in ^ r_src_old) & bus.src_en;
  assign w_any  = |w_edge;

  // Winner is the highest-index edge; also count edges for collision detect.
  always_comb begin
    w_win      = {CH_W{1'b0}};
    w_edge_cnt = 5'd0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (w_edge[i]) begin
        w_win      = CH_W'(i);
        w_edge_cnt = w_edge_cnt + 5'd1;
      end else begin
        w_win      = w_win;
      end
    end
  end

`ifdef SERIAL_MERGE_LOCK_EN
  localparam int CNT_W = $clog2(LOCK_CYCLES);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_OWNED = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CH_W-1:0]     r_owner;
  logic [CH_W-1:0]     w_owner_nxt;
  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic [CHANNELS-1:0] w_others;

  // Lock FSM: next state, owner, idle counter and output values.
  always_comb begin
    w_state_nxt          = r_state;
    w_owner_nxt          = r_owner;
    w_cnt_nxt            = r_cnt;
    w_tx_nxt             = r_tx_out;
    w_ch_nxt             = r_active_ch;
    w_valid_nxt          = r_active_valid;
    w_col_nxt            = 1'b0;
    w_others             = w_edge;
    w_others[r_owner]    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_col_nxt = (w_edge_cnt >= 5'd2);
        if (w_any) begin
          w_state_nxt = ST_OWNED;
          w_owner_nxt = w_win;
          w_tx_nxt    = bus.src_in[w_win];
          w_cnt_nxt   = {CNT_W{1'b0}};
          w_ch_nxt    = w_win;
          w_valid_nxt = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_OWNED: begin
        // Non-owner edges are dropped but reported.
        w_col_nxt = |w_others;
        if (!bus.src_en[r_owner]) begin
          w_state_nxt = ST_IDLE;
          w_tx_nxt    = 1'b1;
          w_valid_nxt = 1'b0;
          w_cnt_nxt   = {CNT_W{1'b0}};
        end else if (w_edge[r_owner]) begin
          w_tx_nxt    = bus.src_in[r_owner];
          w_cnt_nxt   = {CNT_W{1'b0}};
        end else if (r_cnt == CNT_W'(LOCK_CYCLES - 1)) begin
          w_state_nxt = ST_IDLE;
          w_tx_nxt    = 1'b1;
          w_valid_nxt = 1'b0;
          w_cnt_nxt   = {CNT_W{1'b0}};
        end else begin
          w_cnt_nxt   = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_tx_nxt    = 1'b1;
        w_valid_nxt = 1'b0;
        w_cnt_nxt   = {CNT_W{1'b0}};
      end
    endcase
  end

  // Lock FSM state, owner and idle counter registers.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_owner <= {CH_W{1'b0}};
      r_cnt   <= {CNT_W{1'b0}};
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end
`else
  // Last-edge-wins: any enabled edge takes the pin, otherwise hold.
  always_comb begin
    w_tx_nxt    = r_tx_out;
    w_ch_nxt    = r_active_ch;
    w_valid_nxt = r_active_valid;
    w_col_nxt   = (w_edge_cnt >= 5'd2);
    if (w_any) begin
      w_tx_nxt    = bus.src_in[w_win];
      w_ch_nxt    = w_win;
      w_valid_nxt = 1'b1;
    end else begin
      w_tx_nxt    = r_tx_out;
    end
  end
`endif

  // Input history and registered outputs; src_old resets to mark so the
  // first low level after reset counts as an edge.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_src_old      <= {CHANNELS{1'b1}};
      r_tx_out       <= 1'b1;
      r_active_ch    <= {CH_W{1'b0}};
      r_active_valid <= 1'b0;
      r_collision    <= 1'b0;
    end else begin
      r_src_old      <= bus.src_in;
      r_tx_out       <= w_tx_nxt;
      r_active_ch    <= w_ch_nxt;
      r_active_valid <= w_valid_nxt;
      r_collision    <= w_col_nxt;
    end
  end

  assign bus.tx_out       = r_tx_out;
  assign bus.active_ch    = r_active_ch;
  assign bus.active_valid = r_active_valid;
  assign bus.collision    = r_collision;

endmodule

// File: tb/tb_serial_out_merge.sv
// Scoreboard bench for serial_out_merge: stimulus pushes model predictions,
// a monitor pops and compares one entry per clock. Covers both build modes
// (SERIAL_MERGE_LOCK_EN) with a lock length of 8.
module tb_serial_out_merge;
  localparam int CH   = 3;
  localparam int CHW  = 2;
  localparam int LOCK = 8;

  typedef struct packed {
    logic           tx;
    logic [CHW-1:0] ch;
    logic           valid;
    logic           col;
  } exp_t;

  logic clk_sys = 1'b0;
  logic reset_n = 1'b0;
  int   checks  = 0;
  int   errors  = 0;
  exp_t q[$];

  // Reference model state.
  logic           m_tx    = 1'b1;
  logic [CH-1:0]  m_prev  = '1;
  logic [CHW-1:0] m_ch    = '0;
  logic           m_valid = 1'b0;
  logic           m_col   = 1'b0;
  logic           m_owned = 1'b0;
  int             m_owner = 0;
  int             m_idle  = 0;

  logic [CH-1:0]  cur_s;
  logic [CH-1:0]  cur_e;

  serial_out_merge_if #(.CHANNELS(CH), .CH_W(CHW)) bus ();

  serial_out_merge #(.CHANNELS(CH), .LOCK_CYCLES(LOCK), .CH_W(CHW)) dut (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, req);
    end
  endtask

  // Predict the outputs seen after the next rising edge.
  task automatic model_step(input logic [CH-1:0] s, input logic [CH-1:0] e, input logic rn);
    int  n;
    int  win;
    int  others;
    logic owner_edge;
    n = 0; win = 0; others = 0;
    if (!rn) begin
      m_tx = 1'b1; m_prev = '1; m_ch = '0; m_valid = 1'b0; m_col = 1'b0;
      m_owned = 1'b0; m_owner = 0; m_idle = 0;
    end else begin
      for (int i = 0; i < CH; i++) begin
        if (s[i] != m_prev[i] && e[i]) begin
          n++;
          win = i;
          if (i != m_owner) others++;
        end
      end
`ifdef SERIAL_MERGE_LOCK_EN
      if (!m_owned) begin
        m_col = (n >= 2);
        if (n > 0) begin
          m_owned = 1'b1; m_owner = win; m_tx = s[win];
          m_ch = win[CHW-1:0]; m_valid = 1'b1; m_idle = 0;
        end
      end else begin
        owner_edge = (s[m_owner] != m_prev[m_owner]) && e[m_owner];
        m_col = (others > 0);
        if (!e[m_owner]) begin
          m_owned = 1'b0; m_tx = 1'b1; m_valid = 1'b0;
        end else if (owner_edge) begin
          m_tx = s[m_owner]; m_idle = 0;
        end else begin
          m_idle++;
          if (m_idle == LOCK) begin
            m_owned = 1'b0; m_tx = 1'b1; m_valid = 1'b0;
          end
        end
      end
`else
      m_col = (n >= 2);
      if (n > 0) begin
        m_tx = s[win]; m_ch = win[CHW-1:0]; m_valid = 1'b1;
      end
`endif
      m_prev = s;
    end
  endtask

  // One clock of stimulus, applied on the falling edge.
  task automatic step(input logic [CH-1:0] s, input logic [CH-1:0] e, input logic rn);
    exp_t x;
    @(negedge clk_sys);
    bus.src_in = s;
    bus.src_en = e;
    cur_s = s;
    cur_e = e;
    if (!rn && reset_n) begin
      reset_n = 1'b0;
      #1;
      chk("async_rst_tx", int'(bus.tx_out), 1);
      chk("async_rst_valid", int'(bus.active_valid), 0);
      chk("async_rst_col", int'(bus.collision), 0);
    end else begin
      reset_n = rn;
    end
    model_step(s, e, rn);
    x.tx = m_tx; x.ch = m_ch; x.valid = m_valid; x.col = m_col;
    q.push_back(x);
  endtask

  task automatic hold(input int n);
    for (int i = 0; i < n; i++) step(cur_s, cur_e, 1'b1);
  endtask

  // Monitor: compare the DUT against the oldest prediction each cycle.
  initial begin : monitor
    exp_t x;
    forever begin
      @(posedge clk_sys);
      #1;
      if (q.size() > 0) begin
        x = q.pop_front();
        chk("tx_out", int'(bus.tx_out), int'(x.tx));
        chk("active_ch", int'(bus.active_ch), int'(x.ch));
        chk("active_valid", int'(bus.active_valid), int'(x.valid));
        chk("collision", int'(bus.collision), int'(x.col));
      end
    end
  end

  initial begin : stimulus
    bus.src_in = 3'b111;
    bus.src_en = 3'b111;
    cur_s = 3'b111;
    cur_e = 3'b111;
    repeat (3) step(3'b111, 3'b111, 1'b0);
    step(3'b111, 3'b111, 1'b1);
    hold(1);
    // ch1 falls
    step(3'b101, 3'b111, 1'b1);
    hold(2);
    // ch0 and ch2 fall together
    step(3'b000, 3'b111, 1'b1);
    hold(2);
    // ch1 masked while it toggles
    step(3'b000, 3'b101, 1'b1);
    step(3'b010, 3'b101, 1'b1);
    hold(2);
    step(3'b010, 3'b111, 1'b1);
    hold(12);
    // ch0 sends 1 then 0 then 1, ch2 toggles 3 cycles later
    step(3'b011, 3'b111, 1'b1);
    step(3'b010, 3'b111, 1'b1);
    step(3'b011, 3'b111, 1'b1);
    hold(2);
    step(3'b111, 3'b111, 1'b1);
    hold(10);
    step(3'b011, 3'b111, 1'b1);
    hold(10);
    // owner edge exactly in the timeout cycle
    step(3'b010, 3'b111, 1'b1);
    hold(7);
    step(3'b011, 3'b111, 1'b1);
    hold(10);
    // owner disabled together with its own edge
    step(3'b010, 3'b111, 1'b1);
    hold(2);
    step(3'b011, 3'b110, 1'b1);
    hold(3);
    step(3'b011, 3'b111, 1'b1);
    hold(10);
    // ch1 low, then reset mid-frame and release with ch1 still low
    step(3'b001, 3'b111, 1'b1);
    hold(2);
    step(3'b001, 3'b111, 1'b0);
    step(3'b001, 3'b111, 1'b0);
    step(3'b001, 3'b111, 1'b1);
    hold(3);
    // randomized traffic with occasional masking and reset
    for (int k = 0; k < 3000; k++) begin
      logic [CH-1:0] s;
      logic [CH-1:0] e;
      logic          rn;
      s = cur_s;
      e = cur_e;
      for (int i = 0; i < CH; i++) begin
        if ($urandom_range(9) == 0) s[i] = ~s[i];
        if ($urandom_range(63) == 0) e[i] = ~e[i];
      end
      rn = ($urandom_range(499) != 0);
      step(s, e, rn);
    end
    @(posedge clk_sys);
    #2;
    chk("scoreboard_drain", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
